mem_arbiter: RTL
================

# mem_arbiter

Fixed-latency controller that shares the single-ported `main_memory` between the instruction-cache fill port and the data-cache fill/write-back port. It arbitrates round-robin, latches the winning request, and holds `addr`/`data_to_write` stable for `MEM_LATENCY` cycles to model off-chip access time. It pulses `wrt_en` for exactly one cycle on writes and returns the full line with a one-cycle `ready` pulse. It sits between the two caches and `main_memory`.

## Interface
- `ADDR_WIDTH`, 32, byte address width, same as `main_memory.addr`.
- `LINE_WIDTH`, `` `MEM_DATA_WIDTH `` (128), line width in bits.
- `MEM_LATENCY`, 5, cycles per access; legal range ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ic_req` in 1: icache read request; `ic_addr` must be held until `ic_ready`.
- `ic_addr` in ADDR_WIDTH: icache line address.
- `ic_ready` out 1: one-cycle pulse; `ic_rdata` is valid in this cycle.
- `ic_rdata` out LINE_WIDTH: returned line.
- `dc_req` in 1: dcache request; `dc_we`, `dc_addr` and `dc_wdata` must be held until `dc_ready`.
- `dc_we` in 1: 1 = write-back, 0 = fill.
- `dc_addr` in ADDR_WIDTH; `dc_wdata` in LINE_WIDTH.
- `dc_ready` out 1: one-cycle completion pulse.
- `dc_rdata` out LINE_WIDTH: returned line; holds its previous value on writes.
- `mem_addr` out ADDR_WIDTH: drives `main_memory.addr`.
- `mem_wdata` out LINE_WIDTH: drives `data_to_write`.
- `mem_wrt_en` out 1: drives `wrt_en`.
- `mem_rdata` in LINE_WIDTH: from `data_to_read`; combinational read.

## Operation
- **FSM states:** IDLE, BUSY, RESP.
- **IDLE:**
  - With no request pending, the FSM stays in IDLE.
  - With any request pending, the arbiter picks a winner, latches its addr/we/wdata into `mem_addr`/`mem_wdata`, loads `cnt = MEM_LATENCY-1`, and moves to BUSY.
- **Arbitration:**
  - With a single requester, that requester wins.
  - With both requesting, the winner is the requester not equal to `last_grant`.
  - `last_grant` updates on each grant.
  - Reset value is `last_grant = IC`, so the first simultaneous request goes to the dcache.
- **BUSY:**
  - `cnt` decrements each cycle.
  - While `cnt == 0` (the final BUSY cycle):
    - on a write, `mem_wrt_en = 1`;
    - on a read, `mem_rdata` is captured into the winner's rdata register.
  - The cycle after the final BUSY cycle, the FSM moves to RESP.
- **RESP:**
  - `ready` for the granted requester is asserted for this one cycle.
  - The next state is IDLE.
- **Re-requests and ignored inputs:**
  - `req` is sampled only in IDLE.
  - A `req` still high in the cycle after `ready` is treated as a new request.
  - Request fields and the other port's `req` are ignored in BUSY and RESP.
- **Data handling:**
  - No data transformation.
  - Address bits are passed through unchanged; `main_memory` does its own word indexing.

## Timing
- **Reset (sync):** next edge sets the following.
  - State IDLE, `cnt = 0`, `last_grant = IC`.
  - `mem_addr = 0`, `mem_wdata = 0`, `mem_wrt_en = 0`.
  - `ic_ready = 0`, `dc_ready = 0`, `ic_rdata = 0`, `dc_rdata = 0`.
- **Latency:** a request seen in IDLE at cycle t produces `ready` at cycle t+MEM_LATENCY+1.
- **Occupancy:** the memory is busy MEM_LATENCY+2 cycles per access including IDLE; throughput is one access per MEM_LATENCY+2 cycles.
- **Write strobe:**
  - `mem_wrt_en` is high for exactly one cycle per write, at cycle t+MEM_LATENCY.
  - It is never high outside BUSY.
- **Stable outputs:** `mem_addr`/`mem_wdata` are registered and stable from t+1 until the next grant. They hold their value in IDLE.
- **`MEM_LATENCY=1`:** BUSY lasts one cycle, and that cycle is the strobe/capture cycle.
- **Reset mid-operation:**
  - Any in-flight access is abandoned and no `ready` is issued.
  - A write is not committed unless its strobe cycle already occurred.
- **Exclusivity:** `ic_ready` and `dc_ready` are never high together.

## Structure
- **Shared header `mem_defs.vh`:**
  - `` `MEM_DATA_WIDTH `` and `` `MEM_DATA_SIZE `` (same defines `main_memory` uses).
  - `MEM_LATENCY` default.
  - FSM state encodings `ST_IDLE`/`ST_BUSY`/`ST_RESP`.
  - Requester IDs `REQ_IC=0`, `REQ_DC=1`.
- **Sub-module:** one, `mem_latency_counter`, a loadable down-counter with `load`, `load_val` and a `zero` flag.
- **Remainder:** FSM, arbitration and output registers live in `mem_arbiter`.
- **Top-level wiring:** `mem_arbiter` is instantiated next to `main_memory` at top level, with `reset` shared.

## Test plan
- **Single read:** preload `memory[0]` via write, then `ic_req=1`, `ic_addr=0x0` at t → `ic_ready` pulses at t+6 with `ic_rdata` = preloaded line; `dc_ready` stays 0.
- **Write then read back:**
  - `dc_we=1`, `dc_addr=0x5`, `dc_wdata=0x...FFFF_FFFF_0000` → `mem_wrt_en` high only at t+5 and `dc_ready` at t+6.
  - A following `dc_we=0` read of `0x5` returns the same line.
- **Simultaneous requests:**
  - `ic_req` and `dc_req` both asserted from reset → dcache served first, icache `ready` exactly 7 cycles after `dc_ready`.
  - A repeat pair alternates the winner.
- **Back-to-back:** `dc_req` held high through `dc_ready` → second access granted the cycle after RESP, with no lost or duplicated `ready`.
- **Reset mid-write:** assert `reset` at t+3 of a write → no `mem_wrt_en` pulse, no `ready`, all outputs 0 next cycle, and the memory location is unchanged.
- **`MEM_LATENCY=1` build:** read `0xF` → `ready` at t+2, with data matching memory.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, latency default, FSM and requester encodings
package mem_arbiter_pkg;

    // Same line width and depth that main_memory is built with.
    localparam int MEM_DATA_WIDTH      = 128;
    localparam int MEM_DATA_SIZE       = 16;

    // Off-chip access time in cycles; any value >= 1 is legal.
    localparam int MEM_LATENCY_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    // Counter width able to hold latency-1; never narrower than one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// rtl/mem_latency_counter.sv - loadable down-counter timing one memory access
module mem_latency_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load wins over counting; the count parks at zero rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fixed-latency arbiter between icache and dcache for main_memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = MEM_DATA_WIDTH,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_ready,
    output logic [LINE_WIDTH-1:0] ic_rdata,
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [LINE_WIDTH-1:0] dc_wdata,
    output logic                  dc_ready,
    output logic [LINE_WIDTH-1:0] dc_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    output logic                  mem_wrt_en,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    localparam int             CNT_W    = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_e                state_q,    state_d;
    // Last granted requester; while an access is in flight it is also its owner.
    req_id_e               grant_q,    grant_d;
    logic                  we_q,       we_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [LINE_WIDTH-1:0] wdata_q,    wdata_d;
    logic [LINE_WIDTH-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_WIDTH-1:0] dc_rdata_q, dc_rdata_d;

    logic cnt_load;
    logic cnt_en;
    logic cnt_zero;

    mem_latency_counter #(
        .WIDTH(CNT_W)
    ) u_latency_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(CNT_LOAD),
        .en      (cnt_en),
        .zero    (cnt_zero)
    );

    assign cnt_en = (state_q == ST_BUSY);

    // Next-state, grant selection, request latching and the strobe/ready outputs.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        cnt_load   = 1'b0;
        mem_wrt_en = 1'b0;
        ic_ready   = 1'b0;
        dc_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ic_req || dc_req) begin
                    if (ic_req && dc_req) begin
                        grant_d = (grant_q == REQ_IC) ? REQ_DC : REQ_IC;
                    end else if (dc_req) begin
                        grant_d = REQ_DC;
                    end else begin
                        grant_d = REQ_IC;
                    end

                    // An icache fill has no write data, so mem_wdata keeps its old value.
                    if (grant_d == REQ_DC) begin
                        we_d    = dc_we;
                        addr_d  = dc_addr;
                        wdata_d = dc_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = ic_addr;
                    end

                    cnt_load = 1'b1;
                    state_d  = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (cnt_zero) begin
                    if (we_q) begin
                        mem_wrt_en = 1'b1;
                    end else if (grant_q == REQ_IC) begin
                        ic_rdata_d = mem_rdata;
                    end else begin
                        dc_rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                ic_ready = (grant_q == REQ_IC);
                dc_ready = (grant_q == REQ_DC);
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= REQ_IC;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;

endmodule
